// File: rtl/riscv_idu.sv
// RV32I instruction decode stage: buffers IFU words in a small FIFO and
// presents decoded fields through a registered valid/ready output stage.
module riscv_idu #(
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        ifu_vld_i,
    input  logic [31:0] ifu_addr_i,
    input  logic [31:0] ifu_data_i,
    output logic        ifu_stall_o,
    input  logic        flush_i,
    output logic        dec_vld_o,
    input  logic        dec_rdy_i,
    output logic [31:0] dec_pc_o,
    output logic [6:0]  dec_opcode_o,
    output logic [4:0]  dec_rd_o,
    output logic [4:0]  dec_rs1_o,
    output logic [4:0]  dec_rs2_o,
    output logic [2:0]  dec_funct3_o,
    output logic [6:0]  dec_funct7_o,
    output logic [31:0] dec_imm_o,
    output logic        dec_illegal_o,
    output logic        ovf_err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN = CW'(STALL_MARGIN);

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall_q, stall_d;
    logic          ovf_q, ovf_d;
    logic          vld_q, vld_d;
    dec_t          dec_q, dec_d;
    dec_t          head;

    logic          out_free;
    logic          push;
    logic          pop;
    logic          full;
    logic [31:0]   inst;

    assign full     = (cnt_q == FULL);
    assign out_free = ~vld_q | dec_rdy_i;
    assign pop      = out_free & (cnt_q != '0) & ~flush_i;
    assign push     = ifu_vld_i & ~flush_i & (~full | pop);
    assign inst     = data_mem[rd_ptr_q];

    always_comb begin
        head         = '0;
        head.pc      = addr_mem[rd_ptr_q];
        head.opcode  = inst[6:0];
        head.rd      = inst[11:7];
        head.rs1     = inst[19:15];
        head.rs2     = inst[24:20];
        head.funct3  = inst[14:12];
        head.funct7  = inst[31:25];
        unique case (inst[6:0])
            7'b0110111, 7'b0010111:
                head.imm = {inst[31:12], 12'b0};
            7'b1101111:
                head.imm = {{11{inst[31]}}, inst[31], inst[19:12],
                            inst[20], inst[30:21], 1'b0};
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011:
                head.imm = {{20{inst[31]}}, inst[31:20]};
            7'b1100011:
                head.imm = {{19{inst[31]}}, inst[31], inst[7],
                            inst[30:25], inst[11:8], 1'b0};
            7'b0100011:
                head.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'b0110011:
                head.imm = '0;
            default: begin
                head.imm     = '0;
                head.illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        vld_d    = vld_q;
        dec_d    = dec_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            vld_d    = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)
                cnt_d = cnt_q + CW'(1);
            else if (pop && !push)
                cnt_d = cnt_q - CW'(1);
            // A full FIFO with no pop this cycle has nowhere to put the word.
            if (ifu_vld_i && full && !pop)
                ovf_d = 1'b1;
            if (pop) begin
                vld_d = 1'b1;
                dec_d = head;
            end else if (out_free) begin
                vld_d = 1'b0;
            end
        end
        stall_d = (FULL - cnt_d) <= MARGIN;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
            dec_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
            vld_q    <= vld_d;
            dec_q    <= dec_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock_i) begin
        if (push && !reset_i) begin
            addr_mem[wr_ptr_q] <= ifu_addr_i;
            data_mem[wr_ptr_q] <= ifu_data_i;
        end
    end

    assign ifu_stall_o   = stall_q;
    assign ovf_err_o     = ovf_q;
    assign dec_vld_o     = vld_q;
    assign dec_pc_o      = dec_q.pc;
    assign dec_opcode_o  = dec_q.opcode;
    assign dec_rd_o      = dec_q.rd;
    assign dec_rs1_o     = dec_q.rs1;
    assign dec_rs2_o     = dec_q.rs2;
    assign dec_funct3_o  = dec_q.funct3;
    assign dec_funct7_o  = dec_q.funct7;
    assign dec_imm_o     = dec_q.imm;
    assign dec_illegal_o = dec_q.illegal;

endmodule

// File: tb/tb_riscv_idu.sv
// Directed bench for riscv_idu: decode formats, backpressure, overflow,
// flush and reset behaviour with hand-computed expectations.
module tb_riscv_idu;

    logic        clock;
    logic        reset;
    logic        ifu_vld;
    logic [31:0] ifu_addr;
    logic [31:0] ifu_data;
    logic        ifu_stall;
    logic        flush;
    logic        dec_vld;
    logic        dec_rdy;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [31:0] dec_imm;
    logic        dec_illegal;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    riscv_idu dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .ifu_vld_i     (ifu_vld),
        .ifu_addr_i    (ifu_addr),
        .ifu_data_i    (ifu_data),
        .ifu_stall_o   (ifu_stall),
        .flush_i       (flush),
        .dec_vld_o     (dec_vld),
        .dec_rdy_i     (dec_rdy),
        .dec_pc_o      (dec_pc),
        .dec_opcode_o  (dec_opcode),
        .dec_rd_o      (dec_rd),
        .dec_rs1_o     (dec_rs1),
        .dec_rs2_o     (dec_rs2),
        .dec_funct3_o  (dec_funct3),
        .dec_funct7_o  (dec_funct7),
        .dec_imm_o     (dec_imm),
        .dec_illegal_o (dec_illegal),
        .ovf_err_o     (ovf_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic vld,
                           input logic [31:0] pc, input logic [31:0] imm);
        chk({tag, ".vld"}, 32'(dec_vld), 32'(vld));
        chk({tag, ".pc"}, dec_pc, pc);
        chk({tag, ".imm"}, dec_imm, imm);
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] d);
        ifu_vld  = v;
        ifu_addr = a;
        ifu_data = d;
    endtask

    // addi x1,x0,k : I-type with immediate k
    function automatic logic [31:0] addi(input int k);
        return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        dec_rdy = 1'b1;
        drive(1'b0, '0, '0);
        do_reset();

        chk("rst.vld", 32'(dec_vld), 32'd0);
        chk("rst.pc", dec_pc, 32'd0);
        chk("rst.imm", dec_imm, 32'd0);
        chk("rst.stall", 32'(ifu_stall), 32'd0);
        chk("rst.ovf", 32'(ovf_err), 32'd0);
        chk("rst.ill", 32'(dec_illegal), 32'd0);

        // addi x1,x2,5 latency
        drive(1'b1, 32'h80, 32'h00510093);
        tick();
        drive(1'b0, '0, '0);
        chk("lat.n1", 32'(dec_vld), 32'd0);
        tick();
        chk_dec("addi", 1'b1, 32'h80, 32'h5);
        chk("addi.op", 32'(dec_opcode), 32'h13);
        chk("addi.rd", 32'(dec_rd), 32'd1);
        chk("addi.rs1", 32'(dec_rs1), 32'd2);
        chk("addi.ill", 32'(dec_illegal), 32'd0);
        tick();
        chk("drain", 32'(dec_vld), 32'd0);

        // back-to-back stream, one per cycle
        drive(1'b1, 32'h100, 32'hFE000EE3);
        tick();
        drive(1'b1, 32'h104, 32'h123450B7);
        tick();
        chk_dec("beq", 1'b1, 32'h100, 32'hFFFFFFFC);
        drive(1'b1, 32'h108, 32'h00000000);
        tick();
        chk_dec("lui", 1'b1, 32'h104, 32'h12345000);
        chk("lui.rd", 32'(dec_rd), 32'd1);
        drive(1'b1, 32'h10C, 32'h00512423);
        tick();
        chk_dec("zero", 1'b1, 32'h108, 32'h0);
        chk("zero.ill", 32'(dec_illegal), 32'd1);
        drive(1'b1, 32'h110, 32'h010000EF);
        tick();
        chk_dec("sw", 1'b1, 32'h10C, 32'h8);
        chk("sw.ill", 32'(dec_illegal), 32'd0);
        drive(1'b1, 32'h114, 32'h002081B3);
        tick();
        chk_dec("jal", 1'b1, 32'h110, 32'h10);
        drive(1'b1, 32'h118, 32'hFFFFFFFF);
        tick();
        chk_dec("add", 1'b1, 32'h114, 32'h0);
        chk("add.rd", 32'(dec_rd), 32'd3);
        chk("add.rs1", 32'(dec_rs1), 32'd1);
        chk("add.rs2", 32'(dec_rs2), 32'd2);
        chk("add.f3", 32'(dec_funct3), 32'd0);
        chk("add.f7", 32'(dec_funct7), 32'd0);
        chk("stream.stall", 32'(ifu_stall), 32'd0);
        drive(1'b0, '0, '0);
        tick();
        chk_dec("ill7f", 1'b1, 32'h118, 32'h0);
        chk("ill7f.ill", 32'(dec_illegal), 32'd1);
        chk("ill7f.f7", 32'(dec_funct7), 32'h7F);
        tick();
        chk("stream.end", 32'(dec_vld), 32'd0);

        // backpressure: hold P0 in output, fill FIFO, overflow
        drive(1'b1, 32'h200, addi(0));
        tick();
        drive(1'b0, '0, '0);
        tick();
        dec_rdy = 1'b0;
        chk_dec("bp.p0", 1'b1, 32'h200, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'h200 + 32'(4 * k), addi(k));
            tick();
            chk_dec("bp.hold", 1'b1, 32'h200, 32'd0);
            chk("bp.stall", 32'(ifu_stall), (k >= 2) ? 32'd1 : 32'd0);
            chk("bp.ovf0", 32'(ovf_err), 32'd0);
        end
        drive(1'b1, 32'h214, addi(5));
        tick();
        chk("bp.ovf", 32'(ovf_err), 32'd1);
        chk_dec("bp.hold5", 1'b1, 32'h200, 32'd0);
        drive(1'b0, '0, '0);
        dec_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_dec("bp.out", 1'b1, 32'h200 + 32'(4 * k), 32'(k));
            chk("bp.dstall", 32'(ifu_stall), (k <= 2) ? 32'd1 : 32'd0);
        end
        tick();
        chk("bp.empty", 32'(dec_vld), 32'd0);
        chk("bp.ovfsticky", 32'(ovf_err), 32'd1);

        // full FIFO with simultaneous pop and push
        do_reset();
        chk("full.ovfclr", 32'(ovf_err), 32'd0);
        drive(1'b1, 32'h300, addi(0));
        tick();
        drive(1'b0, '0, '0);
        tick();
        dec_rdy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'h300 + 32'(4 * k), addi(k));
            tick();
        end
        dec_rdy = 1'b1;
        drive(1'b1, 32'h314, addi(5));
        tick();
        drive(1'b0, '0, '0);
        chk_dec("full.p1", 1'b1, 32'h304, 32'd1);
        chk("full.ovf", 32'(ovf_err), 32'd0);
        chk("full.stall", 32'(ifu_stall), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk_dec("full.out", 1'b1, 32'h300 + 32'(4 * k), 32'(k));
        end
        tick();
        chk("full.empty", 32'(dec_vld), 32'd0);

        // flush with three buffered and a concurrent fetch
        dec_rdy = 1'b0;
        drive(1'b1, 32'h400, addi(0));
        tick();
        drive(1'b0, '0, '0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 32'h400 + 32'(4 * k), addi(k));
            tick();
        end
        chk("fl.prestall", 32'(ifu_stall), 32'd1);
        flush = 1'b1;
        dec_rdy = 1'b1;
        drive(1'b1, 32'h410, addi(4));
        tick();
        flush = 1'b0;
        chk("fl.vld", 32'(dec_vld), 32'd0);
        chk("fl.stall", 32'(ifu_stall), 32'd0);
        chk("fl.ovf", 32'(ovf_err), 32'd0);
        drive(1'b1, 32'h500, addi(9));
        tick();
        drive(1'b0, '0, '0);
        chk("fl.n1", 32'(dec_vld), 32'd0);
        tick();
        chk_dec("fl.new", 1'b1, 32'h500, 32'd9);
        tick();
        chk("fl.empty", 32'(dec_vld), 32'd0);

        // reset mid-stream with FIFO full and overflow set
        dec_rdy = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            drive(1'b1, 32'h600 + 32'(4 * k), addi(k));
            tick();
        end
        drive(1'b0, '0, '0);
        chk("mr.ovf", 32'(ovf_err), 32'd1);
        chk("mr.stall", 32'(ifu_stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr.vld", 32'(dec_vld), 32'd0);
        chk("mr.pc", dec_pc, 32'd0);
        chk("mr.imm", dec_imm, 32'd0);
        chk("mr.op", 32'(dec_opcode), 32'd0);
        chk("mr.rd", 32'(dec_rd), 32'd0);
        chk("mr.stall0", 32'(ifu_stall), 32'd0);
        chk("mr.ovf0", 32'(ovf_err), 32'd0);
        dec_rdy = 1'b1;
        tick();
        tick();
        chk("mr.empty", 32'(dec_vld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
